// File: rtl/data0_packet_assembler_pkg.sv
// Shared definitions for the DATA0 packet assembler and the downstream
// Data0_pack unpack/check stage: packet geometry and FSM state encodings.
package data0_packet_assembler_pkg;

    // Full DATA0 packet: PID (8) + 128 data bytes (1024) + CRC16 (16)
    localparam int PACKET_WIDTH = 1048;
    localparam int PKT_BYTES    = PACKET_WIDTH / 8;

    // Index of the final (CRC low) byte within a packet
    localparam logic [7:0] LAST_IDX = 8'(PKT_BYTES - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_HOLD    = 2'd2,
        ST_DRAIN   = 2'd3
    } state_e;

    // Top bit of byte lane k inside the packet word; byte 0 (PID) sits at the MSBs
    function automatic logic [10:0] lane_top(input logic [7:0] idx);
        return 11'(PACKET_WIDTH - 1) - {idx, 3'b000};
    endfunction

endpackage

// File: rtl/data0_packet_assembler.sv
// Byte-serial to parallel assembler for DATA0 packets. Collects PID, payload
// and CRC bytes into one packet word, holds it under valid/ready, and flags
// framing errors (short, long, restart) with a one-cycle len_error pulse.
// CRC and PID checking are left to the downstream stage.
module data0_packet_assembler
    import data0_packet_assembler_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset_L,
    input  logic [7:0]              byte_in,
    input  logic                    byte_valid,
    input  logic                    byte_sop,
    input  logic                    byte_eop,
    output logic                    byte_ready,
    output logic [PACKET_WIDTH-1:0] packet_out,
    output logic                    packet_valid,
    input  logic                    packet_ready,
    output logic                    len_error
);

    state_e                  state_q, state_d;
    logic [7:0]              cnt_q, cnt_d;
    logic [PACKET_WIDTH-1:0] pkt_q;
    logic                    valid_q;
    logic                    err_q, err_d;
    logic                    wr_en;
    logic [7:0]              wr_idx;
    logic                    acc;

    // Bytes are refused only while a finished packet waits for the consumer
    assign byte_ready   = (state_q != ST_HOLD);
    assign acc          = byte_valid && byte_ready;
    assign packet_out   = pkt_q;
    assign packet_valid = valid_q;
    assign len_error    = err_q;

    // Next-state, counter, byte-lane write enable and framing-error detection
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        wr_en   = 1'b0;
        wr_idx  = cnt_q;
        unique case (state_q)
            ST_IDLE, ST_DRAIN: begin
                if (acc) begin
                    if (byte_sop) begin
                        wr_en  = 1'b1;
                        wr_idx = 8'd0;
                        if (byte_eop) begin
                            // A one-byte packet can never be complete
                            err_d   = 1'b1;
                            cnt_d   = 8'd0;
                            state_d = ST_IDLE;
                        end else begin
                            cnt_d   = 8'd1;
                            state_d = ST_COLLECT;
                        end
                    end else if (state_q == ST_DRAIN && byte_eop) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_COLLECT: begin
                if (acc) begin
                    wr_en = 1'b1;
                    if (byte_sop) begin
                        // Restart: abandon the partial packet, this byte is the new PID
                        err_d  = 1'b1;
                        wr_idx = 8'd0;
                        if (byte_eop) begin
                            cnt_d   = 8'd0;
                            state_d = ST_IDLE;
                        end else begin
                            cnt_d = 8'd1;
                        end
                    end else if (byte_eop) begin
                        cnt_d = 8'd0;
                        if (cnt_q == LAST_IDX) begin
                            state_d = ST_HOLD;
                        end else begin
                            err_d   = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end else if (cnt_q == LAST_IDX) begin
                        // Packet is full but the sender keeps going
                        err_d   = 1'b1;
                        cnt_d   = 8'd0;
                        state_d = ST_DRAIN;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            ST_HOLD: begin
                if (packet_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // FSM state, byte counter and registered status outputs
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= (state_d == ST_HOLD);
            err_q   <= err_d;
        end
    end

    // Packet word: one byte lane written per accepted byte, frozen during HOLD
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            pkt_q <= '0;
        end else if (wr_en) begin
            pkt_q[lane_top(wr_idx) -: 8] <= byte_in;
        end
    end

endmodule

// File: tb/tb_data0_packet_assembler.sv
// Directed and randomized bench for data0_packet_assembler with a queue-based
// reference model of the packet framing rules.
module tb_data0_packet_assembler;

    logic          clk = 1'b0;
    logic          reset_L;
    logic [7:0]    byte_in;
    logic          byte_valid;
    logic          byte_sop;
    logic          byte_eop;
    logic          byte_ready;
    logic [1047:0] packet_out;
    logic          packet_valid;
    logic          packet_ready;
    logic          len_error;

    always #5 clk = ~clk;

    data0_packet_assembler dut (
        .clk          (clk),
        .reset_L      (reset_L),
        .byte_in      (byte_in),
        .byte_valid   (byte_valid),
        .byte_sop     (byte_sop),
        .byte_eop     (byte_eop),
        .byte_ready   (byte_ready),
        .packet_out   (packet_out),
        .packet_valid (packet_valid),
        .packet_ready (packet_ready),
        .len_error    (len_error)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a packet in progress is just the list of bytes seen since sop
    bit            m_active;
    bit            m_drain;
    bit            m_hold;
    logic [7:0]    m_q[$];
    logic [1047:0] exp_pkt;
    logic [7:0]    fb[0:255];

    task automatic chk(input string tag, input logic [1047:0] obs, input logic [1047:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_drain  = 1'b0;
        m_hold   = 1'b0;
        m_q      = {};
    endtask

    // Drive one cycle, advance the model on the edge, then compare outputs
    task automatic step(input bit v, input logic [7:0] b, input bit s, input bit e, input bit rdy);
        bit acc;
        bit exp_err;
        @(negedge clk);
        byte_valid   = v;
        byte_in      = b;
        byte_sop     = s;
        byte_eop     = e;
        packet_ready = rdy;
        acc     = v && !m_hold;
        exp_err = 1'b0;
        if (m_hold && rdy) m_hold = 1'b0;
        if (acc) begin
            if (s) begin
                if (m_active) exp_err = 1'b1;
                m_active = 1'b1;
                m_drain  = 1'b0;
                m_q      = {};
            end
            if (m_active) begin
                m_q.push_back(b);
                if (e) begin
                    if (m_q.size() == 131) begin
                        for (int k = 0; k < 131; k++) exp_pkt[1047-8*k -: 8] = m_q[k];
                        m_hold = 1'b1;
                    end else begin
                        exp_err = 1'b1;
                    end
                    m_active = 1'b0;
                end else if (m_q.size() == 131) begin
                    exp_err  = 1'b1;
                    m_active = 1'b0;
                    m_drain  = 1'b1;
                end
            end else if (m_drain && e) begin
                m_drain = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        chk("len_error", len_error, exp_err);
        chk("packet_valid", packet_valid, m_hold);
        chk("byte_ready", byte_ready, !m_hold);
        if (m_hold) chk("packet_out", packet_out, exp_pkt);
    endtask

    // Send fb[0..len-1] as one frame (sop on first, eop on last), with optional gaps
    task automatic send_buf(input int len, input int gap_pct);
        for (int i = 0; i < len; i++) begin
            while ($urandom_range(0, 99) < gap_pct) step(1'b0, 8'($urandom), 1'b0, 1'b0, 1'($urandom));
            step(1'b1, fb[i], i == 0, i == len - 1, 1'($urandom));
        end
    endtask

    // Hold off the consumer for n cycles (offering junk bytes), then release
    task automatic release_after(input int n);
        for (int i = 0; i < n; i++) step(1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic fill_rand(input int len);
        for (int i = 0; i < len; i++) fb[i] = 8'($urandom);
    endtask

    int kind;
    int len;
    int cut;

    initial begin
        reset_L      = 1'b0;
        byte_in      = 8'h00;
        byte_valid   = 1'b0;
        byte_sop     = 1'b0;
        byte_eop     = 1'b0;
        packet_ready = 1'b0;
        model_reset();
        exp_pkt = '0;
        #12;
        chk("rst_packet_valid", packet_valid, 1'b0);
        chk("rst_len_error", len_error, 1'b0);
        chk("rst_byte_ready", byte_ready, 1'b1);
        chk("rst_packet_out", packet_out, '0);
        @(negedge clk);
        reset_L = 1'b1;

        // Good packet from the test plan, then backpressure
        fb[0] = 8'h3C;
        for (int i = 0; i < 128; i++) fb[1+i] = 8'(i);
        fb[129] = 8'hAB;
        fb[130] = 8'hCD;
        send_buf(131, 0);
        chk("good_valid", packet_valid, 1'b1);
        chk("good_pid", packet_out[1047:1040], 8'h3C);
        chk("good_data0", packet_out[1039:1032], 8'h00);
        chk("good_data127", packet_out[23:16], 8'h7F);
        chk("good_crc", packet_out[15:0], 16'hABCD);
        release_after(10);
        chk("released_ready", byte_ready, 1'b1);

        // Back-to-back packet accepted immediately after release
        fill_rand(131);
        send_buf(131, 0);
        chk("b2b_valid", packet_valid, 1'b1);
        release_after(0);

        // Short packet: eop on the 50th byte
        fill_rand(50);
        send_buf(50, 0);
        // Long packet: 140 bytes, eop on the last
        fill_rand(140);
        send_buf(140, 0);
        // Single-byte sop+eop
        fill_rand(1);
        send_buf(1, 0);
        // Stray bytes without sop in IDLE are ignored
        for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom), 1'b0, 1'($urandom), 1'b0);

        // Restart: sop at byte 60, then a full good packet
        fill_rand(60);
        send_buf(60, 0);
        fill_rand(131);
        send_buf(131, 10);
        chk("restart_valid", packet_valid, 1'b1);
        release_after(3);

        // Asynchronous reset in the middle of a packet
        fill_rand(70);
        for (int i = 0; i < 70; i++) step(1'b1, fb[i], i == 0, 1'b0, 1'b0);
        #2;
        reset_L = 1'b0;
        #1;
        model_reset();
        chk("mid_rst_packet_valid", packet_valid, 1'b0);
        chk("mid_rst_len_error", len_error, 1'b0);
        chk("mid_rst_byte_ready", byte_ready, 1'b1);
        chk("mid_rst_packet_out", packet_out, '0);
        @(negedge clk);
        reset_L = 1'b1;
        fill_rand(131);
        send_buf(131, 0);
        chk("post_rst_valid", packet_valid, 1'b1);

        // Reset while holding a packet
        #2;
        reset_L = 1'b0;
        #1;
        model_reset();
        chk("hold_rst_packet_valid", packet_valid, 1'b0);
        chk("hold_rst_byte_ready", byte_ready, 1'b1);
        @(negedge clk);
        reset_L = 1'b1;

        // Randomized mix of good, short, long and restarted frames
        for (int f = 0; f < 14; f++) begin
            kind = $urandom_range(0, 4);
            case (kind)
                0, 1: len = 131;
                2:    len = $urandom_range(1, 130);
                3:    len = $urandom_range(132, 145);
                default: begin
                    cut = $urandom_range(2, 129);
                    fill_rand(cut);
                    send_buf(cut, 15);
                    len = 131;
                end
            endcase
            fill_rand(len);
            send_buf(len, 15);
            release_after($urandom_range(0, 4));
            for (int i = 0; i < int'($urandom_range(0, 3)); i++)
                step(1'($urandom), 8'($urandom), 1'b0, 1'($urandom), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/data0_packet_assembler.md
# data0_packet_assembler

Byte-serial to parallel assembler for DATA0 endpoint packets. It collects a 131-byte stream (PID, 128 payload bytes, CRC16) into the 1048-bit packet word and presents it to the Data0_pack unpack/check stage with a valid/ready hold. It detects framing errors: short packet, long packet, and restart mid-packet. It performs no CRC or PID checking; the downstream stage owns both.

## Interface
Parameters:
- PKT_BYTES, 131, bytes per packet (1 PID + 128 data + 2 CRC); fixed by `PACKET_WIDTH`/8

Ports:
- clk  in  1  rising-edge clock
- reset_L  in  1  asynchronous, active-low reset
- byte_in  in  8  stream byte
- byte_valid  in  1  byte_in valid this cycle
- byte_sop  in  1  marks first byte (PID) of a packet; qualified by byte_valid
- byte_eop  in  1  marks last byte of a packet; qualified by byte_valid
- byte_ready  out  1  assembler accepts a byte this cycle
- packet_out  out  1048  assembled packet; [1047:1040] PID, [1039:16] data, [15:0] CRC
- packet_valid  out  1  packet_out complete and stable
- packet_ready  in  1  downstream consumes packet_out
- len_error  out  1  one-cycle pulse on a framing error

## Operation
- A byte is accepted when byte_valid && byte_ready.
- byte_ready = 1 in IDLE, COLLECT and DRAIN; 0 in HOLD.
- Byte k (k = 0..130) is written to packet_out[1047-8k -: 8]:
  - byte 0 is the PID;
  - bytes 129 and 130 are CRC[15:8] and CRC[7:0].
- 8-bit byte counter cnt counts 0..130.

States:
- IDLE: accepted byte with sop → store as byte 0, cnt=1, go to COLLECT. Accepted byte without sop → ignore, no error.
  - If that sop byte also carries eop → len_error pulse, stay in IDLE.
- COLLECT: accepted byte without sop → store at cnt, cnt+1.
  - eop with cnt==130 → go to HOLD.
  - eop with cnt<130 → len_error (short), go to IDLE.
  - cnt==130 without eop → len_error (long), go to DRAIN.
  - sop mid-packet → len_error (restart), then treat that byte as byte 0 (cnt=1), stay in COLLECT.
- HOLD: packet_valid=1, packet_out frozen.
  - packet_ready=1 → go to IDLE.
- DRAIN: discard accepted bytes until eop, then go to IDLE.
  - sop in DRAIN → start a new packet as in IDLE, go to COLLECT.
- On error, previous packet_out contents are not cleared; only packet_valid qualifies them.
- Bytes of a partially collected packet are overwritten by the next packet and never exposed.

## Timing
- Reset values: state=IDLE, cnt=0, packet_out=0, packet_valid=0, len_error=0, byte_ready=1 (combinational from state).
- Latency: packet_valid rises the cycle after the eop byte is accepted; minimum 131 cycles from sop to packet_valid.
- packet_valid and packet_out are registered; packet_out is stable for every cycle packet_valid=1.
- HOLD with packet_ready=1: packet_valid drops next cycle and byte_ready is 1 that same next cycle. Back-to-back throughput is one packet per 132 cycles.
- len_error is registered: one pulse per error event, one cycle after the offending byte.
- A sop+error restart produces exactly one pulse.
- packet_ready while not in HOLD is ignored.
- byte_valid=0 cycles inside a packet are allowed (gaps) and do not advance cnt.
- Asynchronous reset mid-packet or in HOLD discards the packet immediately; no len_error is produced.

## Structure
- Add `PACKET_WIDTH` (1048), `PKT_BYTES` (131) and the state encodings (IDLE, COLLECT, HOLD, DRAIN) to Defintions.v, shared with Data0_pack.
- Single module, no sub-modules: a 2-bit FSM, an 8-bit counter, and a byte-lane write-enable into the packet register.

## Test plan
- Good packet: sop byte 0x3C, data bytes 0x00..0x7F, CRC bytes 0xAB, 0xCD with eop → packet_valid one cycle after eop.
  - packet_out[1047:1040]=0x3C, [1039:1032]=0x00, [23:16]=0x7F, [15:0]=0xABCD; len_error never asserted.
- Backpressure: packet_ready held 0 for 10 cycles → packet_valid and packet_out stable, byte_ready=0 throughout; packet_ready=1 → IDLE next cycle, next sop accepted.
- Short packet: eop on byte 50 → one len_error pulse, no packet_valid, state IDLE.
- Long packet: 140 bytes, eop on last → len_error pulse at byte 131; bytes 131..139 discarded; no packet_valid.
- Restart: sop at byte 60, followed by a full good 131-byte packet → one len_error pulse, then packet_valid holding the second packet only.
- Reset mid-packet: reset_L low at byte 70 → all outputs at reset values; a following good packet assembles correctly.
